// File: rtl/sel_mux_pipe.sv
// ---------------------------------------------------------------------------
// sel_mux_pipe
//   Selects one of NUM_IN valid/ready input channels, either by a fixed
//   index (mode = 0) or by a round-robin scan (mode = 1).
//   The selected beat is captured in a single-entry output register.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active high
//   in_data    : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel accept (combinational, one-hot or zero)
//   sel        : channel index used in fixed mode
//   mode       : 0 = fixed select, 1 = round-robin
//   out_data   : registered selected data
//   out_ch     : registered index of the channel that produced out_data
//   out_valid  : output register holds a beat
//   out_ready  : downstream accept
//   out_parity : even parity of out_data (only with SEL_MUX_PIPE_PARITY_EN)
//
// Build option
//   SEL_MUX_PIPE_PARITY_EN : adds the registered out_parity output.
// ---------------------------------------------------------------------------
module sel_mux_pipe #(
    parameter int WIDTH  = 2,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
`ifdef SEL_MUX_PIPE_PARITY_EN
    output logic                    out_parity,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load_en;
    logic              w_rr_hit;
    logic [SEL_W-1:0]  w_rr_idx;
    logic [SEL_W-1:0]  w_scan_idx;
    logic              w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [WIDTH-1:0]  w_gnt_data;
    logic              w_xfer;

    // Output register can take a new beat when empty or being drained.
    assign w_load_en = !r_out_valid || out_ready;

    // Round-robin scan from r_rr_ptr upward. Offsets are visited from the
    // highest down so the lowest offset (closest to the pointer) wins.
    // NUM_IN is a power of two, so SEL_W-bit addition wraps modulo NUM_IN.
    always_comb begin
        w_rr_hit   = 1'b0;
        w_rr_idx   = r_rr_ptr;
        w_scan_idx = r_rr_ptr;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            w_scan_idx = r_rr_ptr + SEL_W'(i);
            if (in_valid[w_scan_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_scan_idx;
            end
        end
    end

    assign w_gnt_vld  = mode ? w_rr_hit : in_valid[sel];
    assign w_gnt_idx  = mode ? w_rr_idx : sel;
    assign w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];
    assign w_xfer     = !rst && w_load_en && w_gnt_vld;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            in_ready[k] = w_xfer && (w_gnt_idx == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_ch    <= w_gnt_idx;
                // Pointer only moves on round-robin transfers, so fixed-mode
                // traffic never disturbs the fairness order.
                if (mode)
                    r_rr_ptr <= w_gnt_idx + SEL_W'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SEL_MUX_PIPE_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk) begin
        if (rst)
            r_out_parity <= 1'b0;
        else if (w_load_en && w_gnt_vld)
            r_out_parity <= ^w_gnt_data;
    end

    assign out_parity = r_out_parity;
`endif

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// ---------------------------------------------------------------------------
// tb_sel_mux_pipe
//   Directed self-checking bench for sel_mux_pipe (WIDTH=2, NUM_IN=8).
//   Inputs change 1 time unit after the rising edge; in_ready is checked
//   1 unit later, registered outputs 1 unit after the next rising edge.
//   Channel data: ch0=00 ch1=11 ch2=01 ch3=11 ch4=00 ch5=10 ch6=10 ch7=01.
// ---------------------------------------------------------------------------
module tb_sel_mux_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [2:0]  sel;
    logic        mode;
    logic [1:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
`ifdef SEL_MUX_PIPE_PARITY_EN
    logic        out_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sel_mux_pipe #(.WIDTH(2), .NUM_IN(8), .SEL_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
`ifdef SEL_MUX_PIPE_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; leaves time at posedge + 1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got %h exp 00", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++;
        if (out_data !== 2'b00) begin n_fail++; $display("FAIL reset_data got %b exp 00", out_data); end
        n_checks++;
        if (out_ch !== 3'd0) begin n_fail++; $display("FAIL reset_ch got %0d exp 0", out_ch); end
`ifdef SEL_MUX_PIPE_PARITY_EN
        n_checks++;
        if (out_parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b exp 0", out_parity); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'h20) begin n_fail++; $display("FAIL fixed_in_ready got %h exp 20", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_valid got %b exp 1", out_valid); end
        n_checks++;
        if (out_data !== 2'b10) begin n_fail++; $display("FAIL fixed_data got %b exp 10", out_data); end
        n_checks++;
        if (out_ch !== 3'd5) begin n_fail++; $display("FAIL fixed_ch got %0d exp 5", out_ch); end
    endtask

    task automatic test_fixed_idle();
        mode = 1'b0; sel = 3'd3; in_valid = 8'hF7; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL idle_in_ready got %h exp 00", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", out_valid); end
        n_checks++;
        if (out_data !== 2'b10) begin n_fail++; $display("FAIL idle_data_hold got %b exp 10", out_data); end
        n_checks++;
        if (out_ch !== 3'd5) begin n_fail++; $display("FAIL idle_ch_hold got %0d exp 5", out_ch); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ch [5];
        logic [1:0] exp_d  [5];
        logic [7:0] exp_rdy[5];
        exp_ch  = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        exp_d   = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        exp_rdy = '{8'h01, 8'h04, 8'h80, 8'h01, 8'h04};
        do_reset();
        mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== exp_rdy[i]) begin n_fail++; $display("FAIL rr_in_ready[%0d] got %h exp %h", i, in_ready, exp_rdy[i]); end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[i] || out_data !== exp_d[i]) begin
                n_fail++;
                $display("FAIL rr_beat[%0d] got v=%b ch=%0d d=%b exp v=1 ch=%0d d=%b",
                         i, out_valid, out_ch, out_data, exp_ch[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_rr_empty();
        mode = 1'b1; in_valid = 8'h00; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL rr_empty_in_ready got %h exp 00", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_ch !== 3'd2) begin
            n_fail++; $display("FAIL rr_empty_out got v=%b ch=%0d exp v=0 ch=2", out_valid, out_ch);
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 3'd2; in_valid = 8'hFF; out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 2'b01 || out_ch !== 3'd2) begin
            n_fail++; $display("FAIL bp_load got v=%b d=%b ch=%0d exp v=1 d=01 ch=2", out_valid, out_data, out_ch);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 3'(i + 5); mode = i[0]; in_valid = 8'hF0 | 8'(i);
            #1;
            n_checks++;
            if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %h exp 00", i, in_ready); end
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 2'b01 || out_ch !== 3'd2) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%b ch=%0d exp v=1 d=01 ch=2", i, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1; mode = 1'b0; sel = 3'd6; in_valid = 8'hFF;
        #1;
        n_checks++;
        if (in_ready !== 8'h40) begin n_fail++; $display("FAIL bp_release_in_ready got %h exp 40", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 2'b10 || out_ch !== 3'd6) begin
            n_fail++; $display("FAIL bp_release got v=%b d=%b ch=%0d exp v=1 d=10 ch=6", out_valid, out_data, out_ch);
        end
    endtask

    // rr_ptr must survive fixed-mode traffic and mode changes.
    task automatic test_mode_switch();
        do_reset();
        mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1;
        step();
        n_checks++;
        if (out_ch !== 3'd0) begin n_fail++; $display("FAIL ms_first got %0d exp 0", out_ch); end
        mode = 1'b0; sel = 3'd7; in_valid = 8'h80;
        step();
        n_checks++;
        if (out_ch !== 3'd7 || out_data !== 2'b01) begin
            n_fail++; $display("FAIL ms_fixed got ch=%0d d=%b exp ch=7 d=01", out_ch, out_data);
        end
        mode = 1'b1; in_valid = 8'b1000_0101;
        #1;
        n_checks++;
        if (in_ready !== 8'h04) begin n_fail++; $display("FAIL ms_rr_resume_in_ready got %h exp 04", in_ready); end
        step();
        n_checks++;
        if (out_ch !== 3'd2) begin n_fail++; $display("FAIL ms_rr_resume got %0d exp 2", out_ch); end
    endtask

    task automatic test_reset_midstream();
        // State: out_valid=1 (ch2), rr_ptr=3, channel 7 would be next.
        mode = 1'b1; in_valid = 8'b1000_0101; out_ready = 1'b1; rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL mid_rst_in_ready got %h exp 00", in_ready); end
        step();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_ch !== 3'd0 || out_data !== 2'b00) begin
            n_fail++; $display("FAIL mid_rst_out got v=%b ch=%0d d=%b exp v=0 ch=0 d=00", out_valid, out_ch, out_data);
        end
        #1;
        n_checks++;
        if (in_ready !== 8'h01) begin n_fail++; $display("FAIL mid_rst_ptr got in_ready %h exp 01", in_ready); end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'd0) begin
            n_fail++; $display("FAIL mid_rst_first got v=%b ch=%0d exp v=1 ch=0", out_valid, out_ch);
        end
    endtask

`ifdef SEL_MUX_PIPE_PARITY_EN
    task automatic test_parity();
        mode = 1'b0; sel = 3'd1; in_valid = 8'hFF; out_ready = 1'b1;
        step();
        n_checks++;
        if (out_data !== 2'b11 || out_parity !== 1'b0) begin
            n_fail++; $display("FAIL parity_11 got d=%b p=%b exp d=11 p=0", out_data, out_parity);
        end
        sel = 3'd5;
        step();
        n_checks++;
        if (out_data !== 2'b10 || out_parity !== 1'b1) begin
            n_fail++; $display("FAIL parity_10 got d=%b p=%b exp d=10 p=1", out_data, out_parity);
        end
        in_valid = 8'h00;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_parity !== 1'b1) begin
            n_fail++; $display("FAIL parity_hold got v=%b p=%b exp v=0 p=1", out_valid, out_parity);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 3'd0; out_ready = 1'b0; in_valid = 8'h00;
        in_data = 16'b01_10_10_00_11_01_11_00;
        step();
        test_reset();
        test_fixed();
        test_fixed_idle();
        test_round_robin();
        test_rr_empty();
        test_backpressure();
        test_mode_switch();
        test_reset_midstream();
`ifdef SEL_MUX_PIPE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
